// File: rtl/alut_pkg.sv
// Shared ALUT definitions: memory geometry, entry field layout, requester ids
// and the lock FSM encoding used by the memory arbiter.
package alut_pkg;

    localparam int AW = 8;
    localparam int DW = 83;

    // Entry layout: {valid, time[31:0], port[1:0], addr[47:0]}
    localparam int ENT_VALID_BIT = 82;
    localparam int ENT_TIME_MSB  = 81;
    localparam int ENT_TIME_LSB  = 50;
    localparam int ENT_PORT_MSB  = 49;
    localparam int ENT_PORT_LSB  = 48;
    localparam int ENT_ADDR_MSB  = 47;
    localparam int ENT_ADDR_LSB  = 0;

    typedef enum logic [1:0] {
        ADD  = 2'd0,
        SW   = 2'd1,
        AGE  = 2'd2,
        NONE = 2'd3
    } req_id_e;

    typedef enum logic {
        LK_IDLE   = 1'b0,
        LK_LOCKED = 1'b1
    } lock_st_e;

    // Grant vector bit order is {age, sw, add}
    function automatic logic [2:0] id_to_onehot(input req_id_e id);
        logic [2:0] oh;
        case (id)
            ADD:     oh = 3'b001;
            SW:      oh = 3'b010;
            AGE:     oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/alut_mem_arb_if.sv
// Requester and memory-side signal bundle of the ALUT memory arbiter.
interface alut_mem_arb_if #(
    parameter int AW = alut_pkg::AW,
    parameter int DW = alut_pkg::DW
);
    logic          add_req;
    logic          add_we;
    logic [AW-1:0] add_addr;
    logic [DW-1:0] add_wdata;
    logic          add_lock;
    logic          add_gnt;
    logic          add_rvalid;

    logic          sw_req;
    logic          sw_we;
    logic [AW-1:0] sw_addr;
    logic [DW-1:0] sw_wdata;
    logic          sw_gnt;
    logic          sw_rvalid;

    logic          age_req;
    logic          age_we;
    logic [AW-1:0] age_addr;
    logic [DW-1:0] age_wdata;
    logic          age_gnt;
    logic          age_rvalid;

    logic [DW-1:0] rdata;
    logic          mem_cs;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          arb_busy;

    modport slave (
        input  add_req, add_we, add_addr, add_wdata, add_lock,
        input  sw_req, sw_we, sw_addr, sw_wdata,
        input  age_req, age_we, age_addr, age_wdata,
        input  mem_rdata,
        output add_gnt, add_rvalid, sw_gnt, sw_rvalid, age_gnt, age_rvalid,
        output rdata, mem_cs, mem_we, mem_addr, mem_wdata, arb_busy
    );

    modport master (
        output add_req, add_we, add_addr, add_wdata, add_lock,
        output sw_req, sw_we, sw_addr, sw_wdata,
        output age_req, age_we, age_addr, age_wdata,
        output mem_rdata,
        input  add_gnt, add_rvalid, sw_gnt, sw_rvalid, age_gnt, age_rvalid,
        input  rdata, mem_cs, mem_we, mem_addr, mem_wdata, arb_busy
    );

endinterface

// File: rtl/alut_arb_prio.sv
// Fixed-priority winner select (add > sw > age) with lock hold-off and
// a one-shot age override when the age sweeper has starved.
module alut_arb_prio
    import alut_pkg::*;
(
    input  logic    en,
    input  logic    locked,
    input  logic    starve,
    input  logic    add_req,
    input  logic    sw_req,
    input  logic    age_req,
    output req_id_e win_id
);

    // Winner selection; lock beats starvation so a read-modify-write is never split
    always_comb begin
        win_id = NONE;
        if (!en) begin
            win_id = NONE;
        end else if (locked) begin
            if (add_req) begin
                win_id = ADD;
            end else begin
                win_id = NONE;
            end
        end else if (starve && age_req) begin
            win_id = AGE;
        end else if (add_req) begin
            win_id = ADD;
        end else if (sw_req) begin
            win_id = SW;
        end else if (age_req) begin
            win_id = AGE;
        end else begin
            win_id = NONE;
        end
    end

endmodule

// File: rtl/alut_mem_arb.sv
// Three-way ALUT memory arbiter: combinational grant, registered memory issue,
// fixed two-cycle read return routed back through a requester-id pipeline.
module alut_mem_arb #(
    parameter int AW         = alut_pkg::AW,
    parameter int DW         = alut_pkg::DW,
    parameter int STARVE_LIM = 8
) (
    input  logic           pclk,
    input  logic           p_reset,
    alut_mem_arb_if.slave  bus
);
    import alut_pkg::*;

    localparam int CW = $clog2(STARVE_LIM) + 1;

    req_id_e       win_s;
    logic [2:0]    gnt_s;
    logic          arb_en_s;
    logic          locked_s;
    logic          starve_s;
    lock_st_e      lock_st_r;
    lock_st_e      lock_nx_s;
    logic [CW-1:0] starve_cnt_r;

    logic          sel_we_s;
    logic [AW-1:0] sel_addr_s;
    logic [DW-1:0] sel_wdata_s;

    logic          mem_cs_r;
    logic          mem_we_r;
    logic [AW-1:0] mem_addr_r;
    logic [DW-1:0] mem_wdata_r;
    req_id_e       s1_id_r;
    logic          s2_valid_r;
    logic          s2_read_r;
    req_id_e       s2_id_r;

    assign arb_en_s = !p_reset;
    assign locked_s = (lock_st_r == LK_LOCKED);
    assign starve_s = (starve_cnt_r == CW'(STARVE_LIM));

    alut_arb_prio u_prio (
        .en      (arb_en_s),
        .locked  (locked_s),
        .starve  (starve_s),
        .add_req (bus.add_req),
        .sw_req  (bus.sw_req),
        .age_req (bus.age_req),
        .win_id  (win_s)
    );

    assign gnt_s       = id_to_onehot(win_s);
    assign bus.add_gnt = gnt_s[0];
    assign bus.sw_gnt  = gnt_s[1];
    assign bus.age_gnt = gnt_s[2];

    // Lock FSM next state
    always_comb begin
        lock_nx_s = lock_st_r;
        case (lock_st_r)
            LK_IDLE: begin
                if (gnt_s[0] && bus.add_lock) begin
                    lock_nx_s = LK_LOCKED;
                end else begin
                    lock_nx_s = LK_IDLE;
                end
            end
            LK_LOCKED: begin
                if (!bus.add_lock) begin
                    lock_nx_s = LK_IDLE;
                end else begin
                    lock_nx_s = LK_LOCKED;
                end
            end
            default: lock_nx_s = LK_IDLE;
        endcase
    end

    // Lock FSM state register
    always_ff @(posedge pclk) begin
        if (p_reset) begin
            lock_st_r <= LK_IDLE;
        end else begin
            lock_st_r <= lock_nx_s;
        end
    end

    // Age starvation counter, saturating so the override stays armed until age wins
    always_ff @(posedge pclk) begin
        if (p_reset) begin
            starve_cnt_r <= {CW{1'b0}};
        end else if (!bus.age_req || gnt_s[2]) begin
            starve_cnt_r <= {CW{1'b0}};
        end else if (!starve_s) begin
            starve_cnt_r <= starve_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Command mux of the winning requester
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = {AW{1'b0}};
        sel_wdata_s = {DW{1'b0}};
        case (win_s)
            ADD: begin
                sel_we_s    = bus.add_we;
                sel_addr_s  = bus.add_addr;
                sel_wdata_s = bus.add_wdata;
            end
            SW: begin
                sel_we_s    = bus.sw_we;
                sel_addr_s  = bus.sw_addr;
                sel_wdata_s = bus.sw_wdata;
            end
            AGE: begin
                sel_we_s    = bus.age_we;
                sel_addr_s  = bus.age_addr;
                sel_wdata_s = bus.age_wdata;
            end
            default: begin
                sel_we_s    = 1'b0;
                sel_addr_s  = {AW{1'b0}};
                sel_wdata_s = {DW{1'b0}};
            end
        endcase
    end

    // Issue stage and return stage; reset drops anything in flight
    always_ff @(posedge pclk) begin
        if (p_reset) begin
            mem_cs_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {AW{1'b0}};
            mem_wdata_r <= {DW{1'b0}};
            s1_id_r     <= NONE;
            s2_valid_r  <= 1'b0;
            s2_read_r   <= 1'b0;
            s2_id_r     <= NONE;
        end else begin
            mem_cs_r <= (win_s != NONE);
            mem_we_r <= sel_we_s;
            s1_id_r  <= win_s;
            if (win_s != NONE) begin
                mem_addr_r  <= sel_addr_s;
                mem_wdata_r <= sel_wdata_s;
            end else begin
                mem_addr_r  <= mem_addr_r;
                mem_wdata_r <= mem_wdata_r;
            end
            s2_valid_r <= mem_cs_r;
            s2_read_r  <= mem_cs_r && !mem_we_r;
            s2_id_r    <= s1_id_r;
        end
    end

    assign bus.mem_cs    = mem_cs_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;

    // mem_rdata is the RAM output register; forced to zero outside a returning read
    assign bus.rdata      = s2_read_r ? bus.mem_rdata : {DW{1'b0}};
    assign bus.add_rvalid = s2_read_r && (s2_id_r == ADD);
    assign bus.sw_rvalid  = s2_read_r && (s2_id_r == SW);
    assign bus.age_rvalid = s2_read_r && (s2_id_r == AGE);
    assign bus.arb_busy   = locked_s || mem_cs_r || s2_valid_r;

endmodule

// File: tb/tb_alut_mem_arb.sv
// Directed bench for alut_mem_arb: priority vector table plus hand sequences
// for pipelined return, lock, starvation, read-after-write and reset.
module tb_alut_mem_arb;

    localparam int AW = 8;
    localparam int DW = 83;

    logic pclk = 1'b0;
    logic p_reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    alut_mem_arb_if #(.AW(AW), .DW(DW)) bus ();

    alut_mem_arb #(.AW(AW), .DW(DW), .STARVE_LIM(8)) dut (
        .pclk    (pclk),
        .p_reset (p_reset),
        .bus     (bus)
    );

    always #5 pclk = ~pclk;

    function automatic logic [DW-1:0] init_word(input logic [7:0] a);
        return {1'b0, {24'h000000, a}, 2'b00, {40'h0000000000, ~a}};
    endfunction

    function automatic logic [DW-1:0] wd(input logic [7:0] a, input logic [1:0] id);
        return {1'b1, {24'hC0DE00, a}, id, {40'hAB00000000, a}};
    endfunction

    // Synchronous RAM model: one-cycle read latency
    logic [DW-1:0] mem [256];
    bit            mem_wr [256];
    logic [DW-1:0] mem_q = '0;
    always @(posedge pclk) begin
        if (bus.mem_cs) begin
            if (bus.mem_we) begin
                mem[bus.mem_addr]    <= bus.mem_wdata;
                mem_wr[bus.mem_addr] <= 1'b1;
            end else begin
                mem_q <= mem_wr[bus.mem_addr] ? mem[bus.mem_addr] : init_word(bus.mem_addr);
            end
        end
    end
    assign bus.mem_rdata = mem_q;

    // Expected memory contents, maintained from the stimulus side only
    logic [DW-1:0] exp_val [256];
    bit            exp_wr  [256];

    function automatic logic [DW-1:0] exp_word(input logic [7:0] a);
        return exp_wr[a] ? exp_val[a] : init_word(a);
    endfunction

    task automatic exp_set(input logic [7:0] a, input logic [DW-1:0] d);
        exp_val[a] = d;
        exp_wr[a]  = 1'b1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [2:0] gnt_vec();
        return {bus.age_gnt, bus.sw_gnt, bus.add_gnt};
    endfunction

    function automatic logic [2:0] rv_vec();
        return {bus.age_rvalid, bus.sw_rvalid, bus.add_rvalid};
    endfunction

    // req/we bit order {age, sw, add}
    task automatic drive(input logic [2:0] req, input logic [2:0] we, input logic [7:0] aa,
                         input logic [7:0] as_, input logic [7:0] ag, input logic lock);
        bus.add_req = req[0]; bus.add_we = we[0]; bus.add_addr = aa;  bus.add_wdata = wd(aa, 2'd0);
        bus.sw_req  = req[1]; bus.sw_we  = we[1]; bus.sw_addr  = as_; bus.sw_wdata  = wd(as_, 2'd1);
        bus.age_req = req[2]; bus.age_we = we[2]; bus.age_addr = ag;  bus.age_wdata = wd(ag, 2'd2);
        bus.add_lock = lock;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge pclk);
            drive(3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
        end
    endtask

    typedef struct packed {
        logic [2:0] req;
        logic [2:0] we;
        logic [7:0] a_add;
        logic [7:0] a_sw;
        logic [7:0] a_age;
        logic [2:0] exp_gnt;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          v;
        logic          has;
        logic          w_we;
        logic [7:0]    w_addr;
        logic [DW-1:0] w_data;

        vecs[0] = '{req: 3'b011, we: 3'b000, a_add: 8'h01, a_sw: 8'h02, a_age: 8'h03, exp_gnt: 3'b001};
        vecs[1] = '{req: 3'b110, we: 3'b000, a_add: 8'h00, a_sw: 8'h21, a_age: 8'h22, exp_gnt: 3'b010};
        vecs[2] = '{req: 3'b100, we: 3'b000, a_add: 8'h00, a_sw: 8'h00, a_age: 8'h23, exp_gnt: 3'b100};
        vecs[3] = '{req: 3'b101, we: 3'b001, a_add: 8'h40, a_sw: 8'h00, a_age: 8'h24, exp_gnt: 3'b001};
        vecs[4] = '{req: 3'b010, we: 3'b010, a_add: 8'h00, a_sw: 8'h41, a_age: 8'h00, exp_gnt: 3'b010};
        vecs[5] = '{req: 3'b000, we: 3'b000, a_add: 8'h00, a_sw: 8'h00, a_age: 8'h00, exp_gnt: 3'b000};
        vecs[6] = '{req: 3'b111, we: 3'b000, a_add: 8'h40, a_sw: 8'h25, a_age: 8'h26, exp_gnt: 3'b001};
        vecs[7] = '{req: 3'b100, we: 3'b000, a_add: 8'h00, a_sw: 8'h00, a_age: 8'h41, exp_gnt: 3'b100};
        vecs[8] = '{req: 3'b110, we: 3'b110, a_add: 8'h00, a_sw: 8'h42, a_age: 8'h43, exp_gnt: 3'b010};

        // Reset with a request pending: nothing may be granted
        p_reset = 1'b1;
        drive(3'b111, 3'b000, 8'h05, 8'h06, 8'h07, 1'b1);
        repeat (3) @(negedge pclk);
        #1;
        chk("rst_gnt", gnt_vec(), 3'b000);
        chk("rst_mem_cs", bus.mem_cs, 1'b0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 8'h00);
        chk("rst_mem_wdata", bus.mem_wdata, {DW{1'b0}});
        chk("rst_rvalid", rv_vec(), 3'b000);
        chk("rst_rdata", bus.rdata, {DW{1'b0}});
        chk("rst_busy", bus.arb_busy, 1'b0);
        drive(3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
        @(negedge pclk);
        p_reset = 1'b0;
        idle(2);

        // add read 0x3C and sw read 0x10 together; back-to-back grants
        @(negedge pclk);
        drive(3'b011, 3'b000, 8'h3C, 8'h10, 8'h00, 1'b0);
        #1 chk("b2b_c0_gnt", gnt_vec(), 3'b001);
        @(negedge pclk);
        drive(3'b010, 3'b000, 8'h00, 8'h10, 8'h00, 1'b0);
        #1 chk("b2b_c1_gnt", gnt_vec(), 3'b010);
        chk("b2b_c1_cs", bus.mem_cs, 1'b1);
        chk("b2b_c1_addr", bus.mem_addr, 8'h3C);
        chk("b2b_c1_busy", bus.arb_busy, 1'b1);
        @(negedge pclk);
        drive(3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
        #1 chk("b2b_c2_rv", rv_vec(), 3'b001);
        chk("b2b_c2_rdata", bus.rdata, exp_word(8'h3C));
        chk("b2b_c2_addr", bus.mem_addr, 8'h10);
        @(negedge pclk);
        #1 chk("b2b_c3_rv", rv_vec(), 3'b010);
        chk("b2b_c3_rdata", bus.rdata, exp_word(8'h10));
        idle(3);

        // Table of single-shot requests from idle
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            @(negedge pclk);
            drive(v.req, v.we, v.a_add, v.a_sw, v.a_age, 1'b0);
            #1 chk($sformatf("v%0d_gnt", i), gnt_vec(), v.exp_gnt);
            has = |v.exp_gnt;
            case (v.exp_gnt)
                3'b001:  begin w_we = v.we[0]; w_addr = v.a_add; w_data = wd(v.a_add, 2'd0); end
                3'b010:  begin w_we = v.we[1]; w_addr = v.a_sw;  w_data = wd(v.a_sw,  2'd1); end
                3'b100:  begin w_we = v.we[2]; w_addr = v.a_age; w_data = wd(v.a_age, 2'd2); end
                default: begin w_we = 1'b0;    w_addr = 8'h00;   w_data = {DW{1'b0}};        end
            endcase
            if (has && w_we) exp_set(w_addr, w_data);
            @(negedge pclk);
            drive(3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
            #1 chk($sformatf("v%0d_cs", i), bus.mem_cs, has);
            if (has) begin
                chk($sformatf("v%0d_addr", i), bus.mem_addr, w_addr);
                chk($sformatf("v%0d_we", i), bus.mem_we, w_we);
                if (w_we) chk($sformatf("v%0d_wdata", i), bus.mem_wdata, w_data);
            end
            @(negedge pclk);
            #1 chk($sformatf("v%0d_rv", i), rv_vec(), (has && !w_we) ? v.exp_gnt : 3'b000);
            chk($sformatf("v%0d_rdata", i), bus.rdata, (has && !w_we) ? exp_word(w_addr) : {DW{1'b0}});
            @(negedge pclk);
        end
        idle(2);

        // Lock: add read-modify-write of 0x10 while sw and age wait; age starves meanwhile
        for (int c = 0; c < 12; c++) begin
            logic [2:0] req;
            logic [2:0] eg;
            req = {c <= 10, 1'b1, (c == 0) || (c == 2)};
            eg  = (c == 0 || c == 2) ? 3'b001 : (c < 10) ? 3'b000 : (c == 10) ? 3'b100 : 3'b010;
            @(negedge pclk);
            drive(req, {2'b00, c == 2}, 8'h10, 8'h11, 8'h12, c < 9);
            #1 chk($sformatf("lock_c%0d_gnt", c), gnt_vec(), eg);
            if (c == 2) exp_set(8'h10, wd(8'h10, 2'd0));
            if (c == 5) chk("lock_busy", bus.arb_busy, 1'b1);
        end
        idle(3);
        #1 chk("lock_idle_busy", bus.arb_busy, 1'b0);

        // Starvation: add and age both continuous; age wins exactly at cycle 8
        for (int c = 0; c < 10; c++) begin
            @(negedge pclk);
            drive({c <= 8, 1'b0, 1'b1}, 3'b000, 8'(c), 8'h00, 8'h30, 1'b0);
            #1 chk($sformatf("starve_c%0d_gnt", c), gnt_vec(), (c == 8) ? 3'b100 : 3'b001);
        end
        idle(3);

        // sw write 0x55 then age read 0x55 on the next cycle
        @(negedge pclk);
        drive(3'b010, 3'b010, 8'h00, 8'h55, 8'h00, 1'b0);
        #1 chk("raw_c0_gnt", gnt_vec(), 3'b010);
        exp_set(8'h55, wd(8'h55, 2'd1));
        @(negedge pclk);
        drive(3'b100, 3'b000, 8'h00, 8'h00, 8'h55, 1'b0);
        #1 chk("raw_c1_gnt", gnt_vec(), 3'b100);
        chk("raw_c1_we", bus.mem_we, 1'b1);
        chk("raw_c1_wdata", bus.mem_wdata, wd(8'h55, 2'd1));
        @(negedge pclk);
        drive(3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
        #1 chk("raw_c2_rv", rv_vec(), 3'b000);
        @(negedge pclk);
        #1 chk("raw_c3_rv", rv_vec(), 3'b100);
        chk("raw_c3_rdata", bus.rdata, exp_word(8'h55));
        idle(3);

        // Reset right after an add read grant: the read must vanish
        @(negedge pclk);
        drive(3'b001, 3'b000, 8'h3C, 8'h00, 8'h00, 1'b0);
        #1 chk("mrst_c0_gnt", gnt_vec(), 3'b001);
        @(negedge pclk);
        drive(3'b001, 3'b000, 8'h3D, 8'h00, 8'h00, 1'b0);
        p_reset = 1'b1;
        #1 chk("mrst_c1_gnt", gnt_vec(), 3'b000);
        @(negedge pclk);
        #1 chk("mrst_c2_rv", rv_vec(), 3'b000);
        chk("mrst_c2_cs", bus.mem_cs, 1'b0);
        chk("mrst_c2_addr", bus.mem_addr, 8'h00);
        chk("mrst_c2_rdata", bus.rdata, {DW{1'b0}});
        chk("mrst_c2_busy", bus.arb_busy, 1'b0);
        drive(3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
        p_reset = 1'b0;
        @(negedge pclk);
        #1 chk("mrst_c3_rv", rv_vec(), 3'b000);
        @(negedge pclk);
        #1 chk("mrst_c4_rv", rv_vec(), 3'b000);
        chk("mrst_c4_cs", bus.mem_cs, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
